tm1638_ctrl: RTL
================

TM1638_CTRL -- requirements
Module: tm1638_ctrl

Interface
REQ-001 SHALL have parameter clk_mhz, default 27, system clock frequency in MHz; sets serial half-period to clk_mhz cycles (500 kHz tm_clk).
REQ-002 SHALL have parameter w_digit, default 8, number of 7-segment digits driven (max 8).
REQ-003 SHALL have parameter w_led, default 8, number of discrete LEDs (max 8).
REQ-004 SHALL have parameter w_key, default 8, number of keys reported (max 8).
REQ-005 SHALL have parameter brightness, default 7, 3-bit display intensity.
REQ-006 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-008 SHALL have port segs  input  w_digit*8  segments per digit: segs[8k+7:8k] = digit k, MSB = segment a, LSB = h (dot), 1 = lit.
REQ-009 SHALL have port led  input  w_led  LED k lit when led[k] = 1.
REQ-010 SHALL have port key  output  w_key  debounced-by-frame key state, 1 = pressed.
REQ-011 SHALL have port key_valid  output  1  one-cycle pulse when key is updated.
REQ-012 SHALL have port tm_stb  output  1  TM1638 STB, active-low frame select.
REQ-013 SHALL have port tm_clk  output  1  TM1638 serial clock, idle high.
REQ-014 SHALL have port tm_dio_out  output  1  serial data to chip.
REQ-015 SHALL have port tm_dio_oe  output  1  1 = drive DIO; 0 = release for key read.
REQ-016 SHALL have port tm_dio_in  input  1  serial data from chip, sampled directly (synchronized externally).

Function
REQ-017 SHALL loop forever through four STB frames: F1 cmd 0x40; F2 cmd 0xC0 then 16 data bytes; F3 cmd 0x88|brightness; F4 cmd 0x42 then 4 read bytes.
REQ-018 SHALL snapshot segs and led at the start of F2; changes during F2 take effect next loop.
REQ-019 SHALL send F2 data byte 2k = digit k with bit j = segs[8k+7-j], byte 2k+1 = {7'b0, led[k]}; digits/LEDs >= w_digit/w_led send 0x00.
REQ-020 SHALL shift every byte LSB first; tm_dio_out changes while tm_clk low; tm_clk rises after clk_mhz cycles low, stays high clk_mhz cycles.
REQ-021 SHALL hold tm_stb low from clk_mhz cycles before the first falling tm_clk to clk_mhz cycles after the last rising tm_clk, then high for 2*clk_mhz cycles between frames.
REQ-022 SHALL, in F4, release tm_dio_oe after the 0x42 command and wait 2*clk_mhz cycles (tWAIT >= 1 us) before the first read clock.
REQ-023 SHALL sample tm_dio_in on the cycle before each tm_clk rising edge during read bytes.
REQ-024 SHALL map read byte i (0..3): key[i] = bit 0, key[i+4] = bit 4; bits beyond w_key ignored.
REQ-025 SHALL update key and pulse key_valid for one cycle at the end of F4 only (key never shows partial data).
REQ-026 SHALL use state machine IDLE -> STB_SETUP -> SHIFT -> STB_HOLD -> GAP -> (next frame STB_SETUP), with RD_WAIT inserted in F4 between command and read bytes; IDLE lasts one cycle after reset.
REQ-027 SHALL use a 32-bit half-period counter and 5-bit byte counter, both wrapping to 0 at frame end, no overflow for clk_mhz <= 1000.

Reset
REQ-028 SHALL, while rst = 0 at a clk edge, force state IDLE, tm_stb = 1, tm_clk = 1, tm_dio_out = 1, tm_dio_oe = 1, key = 0, key_valid = 0, counters = 0.
REQ-029 SHALL abort any frame on reset mid-operation; tm_stb returns high on the next edge and the loop restarts at F1 after release.

Structure
REQ-030 SHALL place command constants (0x40, 0xC0, 0x88, 0x42) and the state enum in package tm1638_pkg.
REQ-031 SHALL use one sub-module, tm1638_shifter, serializing/deserializing one byte with start/done handshake and the tm_clk timing.

Verification
REQ-032 SHALL test reset: hold rst = 0 for 5 cycles -> tm_stb = tm_clk = tm_dio_oe = 1, key = 0, key_valid = 0.
REQ-033 SHALL test display write with clk_mhz = 2: segs digit 0 = 8'b1000_0000, led = 8'h01 -> F2 bytes 0xC0, 0x01, 0x01, then 0x00 x14.
REQ-034 SHALL test control: brightness = 3 -> F3 byte 0x8B, LSB first on tm_dio_out.
REQ-035 SHALL test key read: chip model returns 0x01, 0x00, 0x10, 0x00 -> key = 8'b0100_0001, single key_valid pulse after F4.
REQ-036 SHALL test reset mid-F2: assert rst during byte 5 -> tm_stb high next edge; after release first frame is F1 (0x40).
REQ-037 SHALL test timing: tm_clk low/high = clk_mhz cycles each, tm_dio_out stable while tm_clk high, RD_WAIT >= 2*clk_mhz cycles.

Source files
------------

// File: rtl/tm1638_pkg.sv
// Shared constants, state encoding and helpers for the TM1638 display/key controller.
package tm1638_pkg;

    localparam logic [7:0] CMD_WRITE   = 8'h40;  // data write, auto-increment address
    localparam logic [7:0] CMD_ADDR    = 8'hC0;  // start address 0
    localparam logic [7:0] CMD_DISPLAY = 8'h88;  // display on, low 3 bits = intensity
    localparam logic [7:0] CMD_READ    = 8'h42;  // read key scan data

    typedef enum logic [2:0] {
        IDLE,
        STB_SETUP,
        SHIFT,
        STB_HOLD,
        GAP,
        RD_WAIT
    } state_t;

    typedef enum logic [1:0] {
        F_MODE,
        F_DATA,
        F_CTRL,
        F_READ
    } frame_t;

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    function automatic logic [4:0] frame_bytes(input frame_t f);
        case (f)
            F_DATA:  return 5'd17;
            F_READ:  return 5'd5;
            default: return 5'd1;
        endcase
    endfunction

endpackage

// File: rtl/tm1638_shifter.sv
// One-byte LSB-first serializer/deserializer with TM1638 clock timing.
// done is asserted in the last low cycle of bit 7; rx_byte is complete in that cycle.
module tm1638_shifter #(
    parameter int half = 27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic       dio_in,
    output logic       busy,
    output logic       done,
    output logic [7:0] rx_byte,
    output logic       sclk,
    output logic       dio_out
);

    localparam logic [31:0] HALF_LAST = 32'(half - 1);

    logic [31:0] cnt;
    logic [2:0]  bit_idx;
    logic        high;
    logic [7:0]  tx_sh;
    logic [7:0]  rx_sh;
    logic        phase_end;

    assign phase_end = (cnt == HALF_LAST);
    assign done      = busy && !high && (bit_idx == 3'd7) && phase_end;
    assign rx_byte   = {dio_in, rx_sh[7:1]};

    // NOTE: every register here uses <= so all updates see the same pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy    <= 1'b0;
            high    <= 1'b0;
            cnt     <= '0;
            bit_idx <= '0;
            tx_sh   <= '0;
            rx_sh   <= '0;
            sclk    <= 1'b1;
            dio_out <= 1'b1;
        end else if (!busy) begin
            if (start) begin
                busy    <= 1'b1;
                high    <= 1'b0;
                cnt     <= '0;
                bit_idx <= '0;
                tx_sh   <= tx_byte;
                dio_out <= tx_byte[0];
                sclk    <= 1'b0;
            end
        end else if (!phase_end) begin
            cnt <= cnt + 32'd1;
        end else begin
            cnt <= '0;
            if (!high) begin
                // last low cycle: capture the chip's bit, then raise the clock
                rx_sh <= rx_byte;
                sclk  <= 1'b1;
                high  <= 1'b1;
                if (bit_idx == 3'd7) busy <= 1'b0;
            end else begin
                sclk    <= 1'b0;
                high    <= 1'b0;
                bit_idx <= bit_idx + 3'd1;
                tx_sh   <= tx_sh >> 1;
                dio_out <= tx_sh[1];
            end
        end
    end

endmodule

// File: rtl/tm1638_ctrl.sv
// TM1638 frame sequencer: mode, display data, display control and key read, looping forever.
// Segment/LED inputs are snapshotted at the start of the data frame; keys update once per loop.
module tm1638_ctrl
    import tm1638_pkg::*;
#(
    parameter int clk_mhz    = 27,
    parameter int w_digit    = 8,
    parameter int w_led      = 8,
    parameter int w_key      = 8,
    parameter int brightness = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [w_digit*8-1:0] segs,
    input  logic [w_led-1:0]     led,
    output logic [w_key-1:0]     key,
    output logic                 key_valid,
    output logic                 tm_stb,
    output logic                 tm_clk,
    output logic                 tm_dio_out,
    output logic                 tm_dio_oe,
    input  logic                 tm_dio_in
);

    localparam logic [31:0] HALF_LAST = 32'(clk_mhz - 1);
    localparam logic [31:0] GAP_LAST  = 32'(2 * clk_mhz - 1);

    state_t      state, state_d;
    frame_t      frame, frame_d;
    logic [31:0] half_cnt, half_d;
    logic [4:0]  byte_cnt, byte_d;
    logic        start, snap, key_load, oe_release, rd_capture;
    logic [1:0]  rd_idx;
    logic [7:0]  key_acc;
    logic [63:0] seg_snap;
    logic [7:0]  led_snap;
    logic [63:0] segs_pad;
    logic [7:0]  led_pad;
    logic [3:0]  data_idx;
    logic [2:0]  digit;
    logic [7:0]  tx_byte, rx_byte;
    logic        sh_busy, sh_done;
    logic        unused_rx;

    assign segs_pad  = 64'(segs);
    assign led_pad   = 8'(led);
    assign unused_rx = ^{rx_byte[7:5], rx_byte[3:1]};

    tm1638_shifter #(.half(clk_mhz)) u_shifter (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .tx_byte (tx_byte),
        .dio_in  (tm_dio_in),
        .busy    (sh_busy),
        .done    (sh_done),
        .rx_byte (rx_byte),
        .sclk    (tm_clk),
        .dio_out (tm_dio_out)
    );

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state;
        frame_d    = frame;
        half_d     = half_cnt;
        byte_d     = byte_cnt;
        start      = 1'b0;
        snap       = 1'b0;
        key_load   = 1'b0;
        oe_release = 1'b0;
        rd_capture = 1'b0;
        rd_idx     = 2'(byte_cnt - 5'd1);
        unique case (state)
            IDLE: state_d = STB_SETUP;
            STB_SETUP, RD_WAIT: begin
                if (state == RD_WAIT && half_cnt == HALF_LAST) oe_release = 1'b1;
                if ((state == STB_SETUP && half_cnt == HALF_LAST) ||
                    (state == RD_WAIT && half_cnt == GAP_LAST)) begin
                    half_d  = '0;
                    start   = 1'b1;
                    state_d = SHIFT;
                end else begin
                    half_d = half_cnt + 32'd1;
                end
            end
            SHIFT: begin
                if (sh_busy) begin
                    if (sh_done) begin
                        half_d     = '0;
                        byte_d     = byte_cnt + 5'd1;
                        rd_capture = (frame == F_READ) && (byte_cnt != 5'd0);
                        if (byte_cnt == frame_bytes(frame) - 5'd1) state_d = STB_HOLD;
                        else if (frame == F_READ && byte_cnt == 5'd0) state_d = RD_WAIT;
                    end
                end else if (half_cnt == HALF_LAST) begin
                    // high half of the previous byte's last bit is over
                    half_d = '0;
                    start  = 1'b1;
                end else begin
                    half_d = half_cnt + 32'd1;
                end
            end
            STB_HOLD: begin
                if (half_cnt == HALF_LAST) begin
                    half_d   = '0;
                    byte_d   = '0;
                    key_load = (frame == F_READ);
                    state_d  = GAP;
                end else begin
                    half_d = half_cnt + 32'd1;
                end
            end
            GAP: begin
                if (half_cnt == GAP_LAST) begin
                    half_d  = '0;
                    frame_d = frame_t'(frame + 2'd1);
                    snap    = (frame_d == F_DATA);
                    state_d = STB_SETUP;
                end else begin
                    half_d = half_cnt + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data_idx = 4'(byte_cnt - 5'd1);
        digit    = data_idx[3:1];
        tx_byte  = 8'hFF;
        unique case (frame)
            F_MODE: tx_byte = CMD_WRITE;
            F_DATA: begin
                if (byte_cnt == 5'd0)  tx_byte = CMD_ADDR;
                else if (data_idx[0])  tx_byte = {7'b0, led_snap[digit]};
                else                   tx_byte = rev8(seg_snap[{digit, 3'b000} +: 8]);
            end
            F_CTRL: tx_byte = CMD_DISPLAY | {5'b0, 3'(brightness)};
            F_READ: tx_byte = (byte_cnt == 5'd0) ? CMD_READ : 8'hFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            frame     <= F_MODE;
            half_cnt  <= '0;
            byte_cnt  <= '0;
            tm_stb    <= 1'b1;
            tm_dio_oe <= 1'b1;
            key       <= '0;
            key_valid <= 1'b0;
            key_acc   <= '0;
        end else begin
            state     <= state_d;
            frame     <= frame_d;
            half_cnt  <= half_d;
            byte_cnt  <= byte_d;
            tm_stb    <= (state_d == IDLE) || (state_d == GAP);
            key_valid <= key_load;
            if (oe_release)    tm_dio_oe <= 1'b0;
            else if (key_load) tm_dio_oe <= 1'b1;
            if (key_load) key <= key_acc[w_key-1:0];
            if (rd_capture) begin
                key_acc[{1'b0, rd_idx}] <= rx_byte[0];
                key_acc[{1'b1, rd_idx}] <= rx_byte[4];
            end
        end
    end

    // NOTE: snapshot registers carry no reset; they are always loaded before the data frame reads them.
    always_ff @(posedge clk) begin
        if (snap) begin
            seg_snap <= segs_pad;
            led_snap <= led_pad;
        end
    end

endmodule
